nios_setup_v2_switch_debounce: RTL and testbench



---
 rtl/nios_setup_v2_switch_debounce.sv | 126 ++++++++++++
 tb/tb_nios_setup_v2_switch_debounce.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_setup_v2_switch_debounce.sv
// rtl/nios_setup_v2_switch_debounce.sv - synchronizer, counter debouncer and edge pulses for switch PIO inputs
// Optional change flag (change_clr/change_flag ports): define SWITCH_DEBOUNCE_CHANGE_FLAG_EN
module nios_setup_v2_switch_debounce #(
   parameter int WIDTH           = 1,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] switch_raw,
   output logic [WIDTH-1:0] switch_out,
   output logic [WIDTH-1:0] rise_pulse,
   output logic [WIDTH-1:0] fall_pulse
`ifdef SWITCH_DEBOUNCE_CHANGE_FLAG_EN
   ,
   input  logic             change_clr,
   output logic             change_flag
`endif
);

   typedef enum logic {
      ST_STABLE  = 1'b0,
      ST_PENDING = 1'b1
   } state_e;

   // Last count value of a qualification; reaching it with the input still
   // different from the accepted level commits the change.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sync1_q;
   logic [WIDTH-1:0] sync2_q;
   logic [WIDTH-1:0] level_q;
   logic [WIDTH-1:0] rise_q;
   logic [WIDTH-1:0] fall_q;
   state_e           state_q [WIDTH];
   logic [CNT_W-1:0] cnt_q   [WIDTH];

   // Two-flop synchronizer; only sync2_q is allowed to reach the debouncer.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= switch_raw;
         sync2_q <= sync1_q;
      end
   end

   // Per-bit debounce FSM; accepted level and edge pulses are registered here
   // so the pulse appears on exactly the edge the level changes.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         level_q <= '0;
         rise_q  <= '0;
         fall_q  <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            state_q[i] <= ST_STABLE;
            cnt_q[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            rise_q[i] <= 1'b0;
            fall_q[i] <= 1'b0;
            case (state_q[i])
               ST_STABLE: begin
                  cnt_q[i] <= '0;
                  if (sync2_q[i] != level_q[i]) begin
                     state_q[i] <= ST_PENDING;
                  end
               end
               ST_PENDING: begin
                  if (sync2_q[i] == level_q[i]) begin
                     // Input fell back before qualifying: treat as bounce.
                     state_q[i] <= ST_STABLE;
                     cnt_q[i]   <= '0;
                  end else if (cnt_q[i] == CNT_LAST) begin
                     level_q[i] <= sync2_q[i];
                     rise_q[i]  <= sync2_q[i];
                     fall_q[i]  <= ~sync2_q[i];
                     state_q[i] <= ST_STABLE;
                     cnt_q[i]   <= '0;
                  end else begin
                     cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                  end
               end
               default: begin
                  state_q[i] <= ST_STABLE;
                  cnt_q[i]   <= '0;
               end
            endcase
         end
      end
   end

   assign switch_out = level_q;
   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;

`ifdef SWITCH_DEBOUNCE_CHANGE_FLAG_EN
   logic change_flag_q;
   logic change_flag_d;

   // Sticky change indication; a pulse in the same cycle beats a clear.
   always_comb begin
      change_flag_d = change_flag_q;
      if (change_clr) begin
         change_flag_d = 1'b0;
      end
      if ((|rise_q) || (|fall_q)) begin
         change_flag_d = 1'b1;
      end
   end

   // Flag register.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         change_flag_q <= 1'b0;
      end else begin
         change_flag_q <= change_flag_d;
      end
   end

   assign change_flag = change_flag_q;
`endif

endmodule

// File: tb/tb_nios_setup_v2_switch_debounce.sv
// tb/tb_nios_setup_v2_switch_debounce.sv - scoreboard bench for nios_setup_v2_switch_debounce
module tb_nios_setup_v2_switch_debounce;

   localparam int WIDTH = 2;
   localparam int DC    = 4;
   localparam int CW    = 3;
   localparam int LAT   = 2 + DC;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [WIDTH-1:0] switch_raw;
   logic [WIDTH-1:0] switch_out;
   logic [WIDTH-1:0] rise_pulse;
   logic [WIDTH-1:0] fall_pulse;
`ifdef SWITCH_DEBOUNCE_CHANGE_FLAG_EN
   logic             change_clr;
   logic             change_flag;
`endif

   nios_setup_v2_switch_debounce #(
      .WIDTH(WIDTH), .DEBOUNCE_CYCLES(DC), .CNT_W(CW)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .switch_raw(switch_raw),
      .switch_out(switch_out),
      .rise_pulse(rise_pulse),
      .fall_pulse(fall_pulse)
`ifdef SWITCH_DEBOUNCE_CHANGE_FLAG_EN
      ,
      .change_clr(change_clr),
      .change_flag(change_flag)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int         edge_n;
      logic [1:0] out;
      logic [1:0] rise;
      logic [1:0] fall;
   } exp_t;

   typedef struct {
      int   edge_n;
      logic val;
   } flag_t;

   exp_t  exp_q[$];
   flag_t flag_q[$];
   exp_t  e;
   flag_t f;

   int         cyc = 0;
   logic       rst_seen = 1'b0;
   logic [1:0] exp_out = 2'b00;
   int         vectors = 0;
   int         miscompares = 0;

   // Edge counter: cyc holds the number of the most recent rising edge.
   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rst_seen <= !reset_n;
   end

   // Monitor: checks reset state, pops the scoreboard on every pulse, and
   // checks the level is held between pulses.
   always @(negedge clk) begin
      if (cyc >= 1) begin
         if (rst_seen) begin
            vectors++;
            if (switch_out !== 2'b00 || rise_pulse !== 2'b00 || fall_pulse !== 2'b00) begin
               miscompares++;
               $display("FAIL reset_state edge %0d: out=%b rise=%b fall=%b, expected all 0",
                        cyc, switch_out, rise_pulse, fall_pulse);
            end
`ifdef SWITCH_DEBOUNCE_CHANGE_FLAG_EN
            vectors++;
            if (change_flag !== 1'b0) begin
               miscompares++;
               $display("FAIL reset_flag edge %0d: flag=%b, expected 0", cyc, change_flag);
            end
`endif
            exp_out = 2'b00;
         end else if (rise_pulse !== 2'b00 || fall_pulse !== 2'b00) begin
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_pulse edge %0d: out=%b rise=%b fall=%b, expected no pulse",
                        cyc, switch_out, rise_pulse, fall_pulse);
            end else begin
               e = exp_q.pop_front();
               if (cyc != e.edge_n || switch_out !== e.out ||
                   rise_pulse !== e.rise || fall_pulse !== e.fall) begin
                  miscompares++;
                  $display("FAIL pulse_event: got edge %0d out=%b rise=%b fall=%b, expected edge %0d out=%b rise=%b fall=%b",
                           cyc, switch_out, rise_pulse, fall_pulse, e.edge_n, e.out, e.rise, e.fall);
               end
               exp_out = e.out;
            end
         end else begin
            vectors++;
            if (switch_out !== exp_out) begin
               miscompares++;
               $display("FAIL level_hold edge %0d: out=%b, expected %b", cyc, switch_out, exp_out);
            end
         end
`ifdef SWITCH_DEBOUNCE_CHANGE_FLAG_EN
         if (flag_q.size() != 0 && flag_q[0].edge_n == cyc) begin
            f = flag_q.pop_front();
            vectors++;
            if (change_flag !== f.val) begin
               miscompares++;
               $display("FAIL change_flag edge %0d: flag=%b, expected %b", cyc, change_flag, f.val);
            end
         end
`endif
      end
   end

   // Return just after edge e-1 so that a value driven now is sampled at edge e.
   task automatic wait_before(input int e);
      while (cyc < e - 1) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive_at(input int e, input logic [1:0] v);
      wait_before(e);
      switch_raw = v;
   endtask

   task automatic expect_ev(input int ed, input logic [1:0] o, input logic [1:0] r, input logic [1:0] fl);
      exp_t x;
      x.edge_n = ed;
      x.out    = o;
      x.rise   = r;
      x.fall   = fl;
      exp_q.push_back(x);
   endtask

   task automatic expect_flag(input int ed, input logic v);
      flag_t x;
      x.edge_n = ed;
      x.val    = v;
      flag_q.push_back(x);
   endtask

   initial begin
      reset_n    = 1'b0;
      switch_raw = 2'b11;
`ifdef SWITCH_DEBOUNCE_CHANGE_FLAG_EN
      change_clr = 1'b0;
`endif
      // Reset held for edges 1..3 with pins high; release edge is 4.
      wait_before(4);
      reset_n = 1'b1;
      expect_ev(4 + LAT, 2'b11, 2'b11, 2'b00);
`ifdef SWITCH_DEBOUNCE_CHANGE_FLAG_EN
      expect_flag(113, 1'b1);
      expect_flag(118, 1'b0);
      expect_flag(126, 1'b0);
      expect_flag(127, 1'b1);
      expect_flag(130, 1'b0);
      expect_flag(140, 1'b0);
      expect_flag(141, 1'b1);
      expect_flag(142, 1'b1);
      expect_flag(144, 1'b1);
      expect_flag(145, 1'b0);
`endif
      // Both bits released together.
      drive_at(12, 2'b00);
      expect_ev(12 + LAT, 2'b00, 2'b00, 2'b11);
      // Clean press and release on bit 0.
      drive_at(22, 2'b01);
      expect_ev(22 + LAT, 2'b01, 2'b01, 2'b00);
      drive_at(32, 2'b00);
      expect_ev(32 + LAT, 2'b00, 2'b00, 2'b01);
      // Bounce on bit 0: 3 high, 1 low, then held high.
      drive_at(42, 2'b01);
      drive_at(45, 2'b00);
      drive_at(46, 2'b01);
      expect_ev(46 + LAT, 2'b01, 2'b01, 2'b00);
      // Glitches on bit 1 of 2 and 4 cycles are rejected.
      drive_at(56, 2'b11);
      drive_at(58, 2'b01);
      drive_at(64, 2'b11);
      drive_at(68, 2'b01);
      // 5-cycle pulse on bit 1 is accepted, and so is its return to 0.
      drive_at(72, 2'b11);
      drive_at(77, 2'b01);
      expect_ev(72 + LAT, 2'b11, 2'b10, 2'b00);
      expect_ev(77 + LAT, 2'b01, 2'b00, 2'b10);
      // Opposite simultaneous changes on both bits.
      drive_at(90, 2'b10);
      expect_ev(90 + LAT, 2'b10, 2'b10, 2'b01);
      // Reset two cycles into a qualification (PENDING from edge 102).
      drive_at(100, 2'b01);
      wait_before(104);
      reset_n = 1'b0;
      wait_before(106);
      reset_n = 1'b1;
      expect_ev(106 + LAT, 2'b01, 2'b01, 2'b00);
`ifdef SWITCH_DEBOUNCE_CHANGE_FLAG_EN
      wait_before(118);
      change_clr = 1'b1;
      wait_before(119);
      change_clr = 1'b0;
      drive_at(120, 2'b11);
      expect_ev(120 + LAT, 2'b11, 2'b10, 2'b00);
      wait_before(130);
      change_clr = 1'b1;
      wait_before(131);
      change_clr = 1'b0;
      drive_at(134, 2'b01);
      expect_ev(134 + LAT, 2'b01, 2'b00, 2'b10);
      // Clear while the fall pulse is high: set wins.
      wait_before(141);
      change_clr = 1'b1;
      wait_before(142);
      change_clr = 1'b0;
      wait_before(145);
      change_clr = 1'b1;
      wait_before(146);
      change_clr = 1'b0;
`endif
      wait_before(160);
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL missing_events: %0d expected pulse events never seen, expected 0 (first at edge %0d)",
                  exp_q.size(), exp_q[0].edge_n);
      end
`ifdef SWITCH_DEBOUNCE_CHANGE_FLAG_EN
      vectors++;
      if (flag_q.size() != 0) begin
         miscompares++;
         $display("FAIL missing_flag_checks: %0d left, expected 0", flag_q.size());
      end
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
